// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECUTER,
        ST_EXECUTEI,
        ST_ALUWB,
        ST_BEQ,
        ST_JAL,
        ST_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/control_alu_decoder.sv
// Maps alu_op plus funct fields to the ALU operation select.
module control_alu_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       funct7_5,
    input  logic [2:0] funct3,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control
);

    logic unused_opcode;
    assign unused_opcode = ^{opcode[6], opcode[4:0]};

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7[5] only means subtract for register-register forms
                    3'b000:  alu_control = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle RV32I datapath with a req/ready memory port.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_write,
    output logic                   adr_src,
    output logic                   ir_write,
    output logic                   pc_update,
    output logic                   reg_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             imm_src,
    output logic [2:0]             alu_control,
    output logic                   instr_done,
    output logic                   illegal_instr
);

    logic [STATE_WIDTH-1:0] state_q;
    state_t                 state;
    state_t                 state_d;
    logic [6:0]             opcode;
    logic                   unused_instr;

    assign state        = state_t'(state_q);
    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXECUTER;
                    OP_ITYPE:          state_d = ST_EXECUTEI;
                    OP_BEQ:            state_d = ST_BEQ;
                    OP_JAL:            state_d = ST_JAL;
                    default:           state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_MEMWB, ST_ALUWB, ST_BEQ: state_d = ST_FETCH;
            ST_EXECUTER, ST_EXECUTEI, ST_JAL: state_d = ST_ALUWB;
            ST_ILLEGAL:  state_d = ST_ILLEGAL;
            default:     state_d = ST_FETCH;
        endcase
    end

    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_update_c;
    logic       reg_write_c, instr_done_c, illegal_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
    logic [2:0] alu_control_c;
    alu_op_t    alu_op;

    always_comb begin
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        reg_write_c  = 1'b0;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRC_A_PC;
        alu_src_b_c  = SRC_B_RS2;
        alu_op       = ALU_OP_ADD;
        case (state)
            ST_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = SRC_B_FOUR;
                result_src_c = RES_ALU;
                ir_write_c   = mem_ready;
                pc_update_c  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a_c = SRC_A_OLDPC;
                alu_src_b_c = SRC_B_IMM;
            end
            ST_MEMADR: begin
                alu_src_a_c = SRC_A_RS1;
                alu_src_b_c = SRC_B_IMM;
            end
            ST_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            ST_MEMWB: begin
                result_src_c = RES_MEM;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_req_c    = 1'b1;
                mem_write_c  = 1'b1;
                adr_src_c    = 1'b1;
                instr_done_c = mem_ready;
            end
            ST_EXECUTER: begin
                alu_src_a_c = SRC_A_RS1;
                alu_op      = ALU_OP_FUNCT;
            end
            ST_EXECUTEI: begin
                alu_src_a_c = SRC_A_RS1;
                alu_src_b_c = SRC_B_IMM;
                alu_op      = ALU_OP_FUNCT;
            end
            ST_ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a_c  = SRC_A_RS1;
                alu_op       = ALU_OP_SUB;
                instr_done_c = 1'b1;
                pc_update_c  = zero;
            end
            ST_JAL: begin
                alu_src_a_c = SRC_A_OLDPC;
                alu_src_b_c = SRC_B_FOUR;
                pc_update_c = 1'b1;
            end
            ST_ILLEGAL: illegal_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE: imm_src_c = IMM_S;
            OP_BEQ:   imm_src_c = IMM_B;
            OP_JAL:   imm_src_c = IMM_J;
            default:  imm_src_c = IMM_I;
        endcase
    end

    control_alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct7_5    (instr[30]),
        .funct3      (instr[14:12]),
        .alu_op      (alu_op),
        .alu_control (alu_control_c)
    );

    // The state register already sits in FETCH during reset, so outputs are masked to stay quiet.
    assign mem_req       = rst_n & mem_req_c;
    assign mem_write     = rst_n & mem_write_c;
    assign adr_src       = rst_n & adr_src_c;
    assign ir_write      = rst_n & ir_write_c;
    assign pc_update     = rst_n & pc_update_c;
    assign reg_write     = rst_n & reg_write_c;
    assign instr_done    = rst_n & instr_done_c;
    assign illegal_instr = rst_n & illegal_c;
    assign result_src    = rst_n ? result_src_c  : '0;
    assign alu_src_a     = rst_n ? alu_src_a_c   : '0;
    assign alu_src_b     = rst_n ? alu_src_b_c   : '0;
    assign imm_src       = rst_n ? imm_src_c     : '0;
    assign alu_control   = rst_n ? alu_control_c : '0;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM controller that sequences a multi-cycle RV32I datapath: shared instruction/data memory, instruction register (IR), old-PC register, ALUOut register and a single ALU.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Adds a req/ready memory handshake so memory latency is variable.
- Replaces the single-cycle control unit in the multi-cycle core variant. It sits beside the datapath and reads the IR contents.

Parameters:
- INSTR_WIDTH, 32, IR width (only 32 supported).
- STATE_WIDTH, 4, FSM state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  INSTR_WIDTH  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a write; valid only with mem_req.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and old-PC.
- pc_update  out  1  PC write enable (includes taken branch).
- reg_write  out  1  register file write.
- result_src  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- alu_src_a  out  2  ALU A input: 00 = PC, 01 = old-PC, 10 = rs1 data.
- alu_src_b  out  2  ALU B input: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- imm_src  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_instr  out  1  sticky flag for an illegal opcode.

Behaviour:
- Reset:
  - State goes to FETCH asynchronously.
  - While rst_n is low, every enable, mem_req, instr_done and illegal_instr is forced to 0.
  - All mux selects are 00 and alu_control is 000.
- Defaults: outputs not listed for a state are 0 / 00. alu_op is internal: 00 add, 01 sub, 10 funct-decoded.
- imm_src is combinational on opcode only: lw/I-ALU = 00, sw = 01, beq = 10, jal = 11, else 00.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready=1: ir_write=1, pc_update=1, next state DECODE.
  - When mem_ready=0: hold FETCH with ir_write=0 and pc_update=0.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target goes to ALUOut).
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; anything else → ILLEGAL.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, mem_write=1, adr_src=1, result_src=00, all held stable while waiting.
  - On mem_ready: instr_done=1, next FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, instr_done=1.
  - pc_update=zero in the same cycle. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB.
- ILLEGAL: terminal state. illegal_instr=1, all write enables and mem_req are 0, exit only by reset.
- alu_control decode:
  - alu_op 00 → 000; alu_op 01 → 001.
  - alu_op 10 by funct3: 000 gives 001 if (opcode[5] & funct7[5]), else 000; 010 → 101; 110 → 011; 111 → 010; other funct3 → 000.
- Latency (cycles): lw 5, sw 4, R/I 4, beq 3, jal 4, each plus memory wait cycles.
- Boundary conditions:
  - mem_ready outside FETCH, MEMREAD or MEMWRITE is ignored.
  - mem_req never drops mid-access except on reset. A reset mid-access abandons the access; memory must tolerate this.
  - instr is sampled only in DECODE and later states; the IR is stable then.

Decomposition:
- Shared package multicycle_pkg holds:
  - state enum (FETCH..ILLEGAL, STATE_WIDTH bits);
  - opcode constants;
  - alu_op, result_src, alu_src_a/b, imm_src and alu_control codes.
- One sub-module, control_alu_decoder, reused unchanged (opcode, funct7_5, funct3, alu_op → alu_control).
- FSM next-state and output decode stay in the top.

Test Plan:
- lw x5,8(x1) = 0x0080A283 with mem_ready tied 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Cycle 5 has reg_write=1, result_src=01, instr_done=1.
- sw x2,4(x1) = 0x0020A223 with mem_ready held 0 for 3 cycles in MEMWRITE → mem_req=mem_write=1 and adr_src=1 stable for 4 cycles, exactly one instr_done.
- beq x1,x2,8 = 0x00208463 → in the BEQ cycle pc_update=1 with zero=1 and 0 with zero=0. Retires in 3 cycles.
- sub x0,x1,x2 = 0x40208033 → alu_control=001 in EXECUTER. addi x1,x0,-1 = 0xFFF00093 → alu_control=000, alu_src_b=01, imm_src=00.
- jal x1,8 = 0x008000EF → imm_src=11; JAL cycle has pc_update=1, alu_src_a=01, alu_src_b=10; then ALUWB has reg_write=1.
- Opcode 0x0000007F → ILLEGAL after DECODE, illegal_instr=1 sticky for 20 cycles with no writes. Separately, rst_n low mid-MEMREAD → mem_req=0 immediately, FETCH with mem_req=1 on release.
